// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t : arbiter FSM states (free arbitration, or locked to port 0/1)
//   mem_req_t   : one memory access (default-width view of a port request)
//   NUM_PORTS   : number of requesters sharing dmem
package dmem_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned ARB_AW    = 32;
  localparam int unsigned ARB_DW    = 32;

  typedef enum logic [1:0] {
    ARB,
    LOCK0,
    LOCK1
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational 2-way round-robin selector.
//   req  : request vector, one bit per port
//   last : index of the port granted most recently
//   gnt  : one-hot grant (all zero when nothing requests)
module rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic [NUM_PORTS-1:0] gnt
);

  // On a tie the port that did not win last time is favoured.
  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] && (!req[1] || last);
    gnt[1] = req[1] && (!req[0] || !last);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data memory.
//   clk, rst                 : clock, synchronous active-high reset
//   pX_req/we/lock/addr/wdata: port X access request (X = 0 processor, 1 loader)
//   pX_gnt                   : port X accepted this cycle (combinational)
//   pX_rvalid/rdata          : registered read response, one cycle after grant
//   mem_we/addr/wdata        : to dmem, muxed from the granted port
//   mem_rdata                : combinational read data from dmem
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic          p0_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } portReq_t;

  arb_state_t state, stateNext;
  logic [CW-1:0] lockCnt, lockCntNext;
  logic last, lastNext;

  logic [NUM_PORTS-1:0] reqV, lockV, weV, rrGnt, gntV;
  portReq_t [NUM_PORTS-1:0] pReq;
  portReq_t memReq;
  logic win, owner;

  logic [NUM_PORTS-1:0] rvalidR;
  logic [NUM_PORTS-1:0][DW-1:0] rdataR;

  assign reqV  = {p1_req, p0_req};
  assign lockV = {p1_lock, p0_lock};
  assign weV   = {p1_we, p0_we};
  assign pReq[0] = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
  assign pReq[1] = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};

  rr_pick uPick (
    .req  (reqV),
    .last (last),
    .gnt  (rrGnt)
  );

  // Grants are masked during reset so nothing is accepted (and no write
  // reaches dmem) in a reset cycle.
  always_comb begin
    gntV = '0;
    unique case (state)
      ARB:   gntV    = rrGnt;
      LOCK0: gntV[0] = reqV[0];
      LOCK1: gntV[1] = reqV[1];
      default: gntV  = '0;
    endcase
    if (rst) gntV = '0;
  end

  assign win   = gntV[1];
  assign owner = (state == LOCK1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      lockCnt <= '0;
      last    <= 1'b1;
    end else begin
      state   <= stateNext;
      lockCnt <= lockCntNext;
      last    <= lastNext;
    end
  end

  // Next state. The owner may idle with lock held; the grant stays reserved
  // until lock drops or the burst reaches MAX_LOCK grants.
  always_comb begin
    stateNext   = state;
    lockCntNext = lockCnt;
    lastNext    = last;
    unique case (state)
      ARB: begin
        if (|gntV) begin
          lastNext = win;
          if (lockV[win] && MAX_LOCK > 1) begin
            stateNext   = win ? LOCK1 : LOCK0;
            lockCntNext = CW'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        if (gntV[owner]) lastNext = owner;
        if (!lockV[owner]) begin
          stateNext   = ARB;
          lockCntNext = '0;
        end else if (gntV[owner]) begin
          if (lockCnt + CW'(1) >= CW'(MAX_LOCK)) begin
            stateNext   = ARB;
            lockCntNext = '0;
          end else begin
            lockCntNext = lockCnt + CW'(1);
          end
        end
      end
      default: begin
        stateNext   = ARB;
        lockCntNext = '0;
      end
    endcase
  end

  // Output mux to dmem
  always_comb begin
    memReq = '0;
    if (gntV[0])      memReq = pReq[0];
    else if (gntV[1]) memReq = pReq[1];
  end

  assign mem_we    = memReq.we;
  assign mem_addr  = memReq.addr;
  assign mem_wdata = memReq.wdata;

  // Read response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalidR <= '0;
      rdataR  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        rvalidR[i] <= gntV[i] && !weV[i];
        if (gntV[i] && !weV[i]) rdataR[i] <= mem_rdata;
      end
    end
  end

  assign p0_gnt    = gntV[0];
  assign p1_gnt    = gntV[1];
  assign p0_rvalid = rvalidR[0];
  assign p1_rvalid = rvalidR[1];
  assign p0_rdata  = rdataR[0];
  assign p1_rdata  = rdataR[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_lock;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_gnt, p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we, p1_lock;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_rvalid;
  logic [31:0] p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int nTests = 0;
  int nFail  = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // dmem: combinational read, write on rising edge
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic setP0(input logic r, input logic w, input logic l,
                       input logic [31:0] a, input logic [31:0] d);
    p0_req = r; p0_we = w; p0_lock = l; p0_addr = a; p0_wdata = d;
  endtask

  task automatic setP1(input logic r, input logic w, input logic l,
                       input logic [31:0] a, input logic [31:0] d);
    p1_req = r; p1_we = w; p1_lock = l; p1_addr = a; p1_wdata = d;
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  task automatic toNext();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'hA000_0000 + k;
    rst = 1'b1;
    setP0(0, 0, 0, 0, 0);
    setP1(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // reset state
    toNeg();
    chk("rst_rv0", p0_rvalid, 0);
    chk("rst_rv1", p1_rvalid, 0);
    chk("rst_rd0", p0_rdata, 0);
    chk("rst_rd1", p1_rdata, 0);
    chk("rst_gnt", {p1_gnt, p0_gnt}, 0);
    chk("rst_we", mem_we, 0);
    toNext();
    rst = 1'b0;

    // p0 write then read back
    setP0(1, 1, 0, 32'h10, 32'hDEADBEEF);
    toNeg();
    chk("wr_gnt0", p0_gnt, 1);
    chk("wr_memwe", mem_we, 1);
    chk("wr_addr", mem_addr, 32'h10);
    toNext();
    setP0(1, 0, 0, 32'h10, 0);
    toNeg();
    chk("rd_gnt0", p0_gnt, 1);
    chk("wr_norv", p0_rvalid, 0);
    toNext();
    setP0(0, 0, 0, 0, 0);
    toNeg();
    chk("rd_rv0", p0_rvalid, 1);
    chk("rd_data0", p0_rdata, 32'hDEADBEEF);
    chk("idle_addr", mem_addr, 0);
    toNext();

    // p1 single read, leaves last = 1
    setP1(1, 0, 0, 32'h30, 0);
    toNeg();
    chk("p1solo_gnt", {p1_gnt, p0_gnt}, 2'b10);
    toNext();
    setP1(0, 0, 0, 0, 0);
    toNeg();
    chk("p1solo_rd", p1_rdata, 32'hA000_000C);
    toNext();

    // alternating reads, no lock
    setP0(1, 0, 0, 32'h0, 0);
    setP1(1, 0, 0, 32'h4, 0);
    toNeg();
    chk("alt1", {p1_gnt, p0_gnt}, 2'b01);
    toNext();
    toNeg();
    chk("alt2", {p1_gnt, p0_gnt}, 2'b10);
    chk("alt2_rv", {p1_rvalid, p0_rvalid}, 2'b01);
    chk("alt2_rd", p0_rdata, 32'hA000_0000);
    toNext();
    toNeg();
    chk("alt3", {p1_gnt, p0_gnt}, 2'b01);
    chk("alt3_rv", {p1_rvalid, p0_rvalid}, 2'b10);
    chk("alt3_rd", p1_rdata, 32'hA000_0001);
    toNext();
    toNeg();
    chk("alt4", {p1_gnt, p0_gnt}, 2'b10);
    chk("alt4_rv", {p1_rvalid, p0_rvalid}, 2'b01);
    toNext();
    setP0(0, 0, 0, 0, 0);
    setP1(0, 0, 0, 0, 0);
    toNeg();
    chk("alt5_rv", {p1_rvalid, p0_rvalid}, 2'b10);
    toNext();

    // p0 alone so last = 0, then p1 locks against a requesting p0
    setP0(1, 0, 0, 32'h0, 0);
    toNext();
    setP1(1, 0, 1, 32'h4, 0);
    for (int i = 1; i <= 12; i++) begin
      toNeg();
      chk($sformatf("lk%0d", i), {p1_gnt, p0_gnt}, (i == 9) ? 2'b01 : 2'b10);
      toNext();
    end
    setP1(0, 0, 0, 0, 0);
    toNeg();
    chk("lk_rel_hold", {p1_gnt, p0_gnt}, 2'b00);
    chk("lk_rel_rv1", p1_rvalid, 1);
    toNext();
    toNeg();
    chk("lk_rel_p0", {p1_gnt, p0_gnt}, 2'b01);
    toNext();
    setP0(0, 0, 0, 0, 0);
    toNext();

    // p0 lock with an idle cycle
    setP0(1, 0, 1, 32'h0, 0);
    toNeg();
    chk("idl1", {p1_gnt, p0_gnt}, 2'b01);
    toNext();
    setP0(0, 0, 1, 32'h0, 0);
    setP1(1, 0, 0, 32'h4, 0);
    toNeg();
    chk("idl2", {p1_gnt, p0_gnt}, 2'b00);
    toNext();
    setP0(1, 0, 0, 32'h0, 0);
    toNeg();
    chk("idl3", {p1_gnt, p0_gnt}, 2'b01);
    toNext();
    setP0(0, 0, 0, 0, 0);
    toNeg();
    chk("idl4", {p1_gnt, p0_gnt}, 2'b10);
    toNext();
    setP1(0, 0, 0, 0, 0);
    toNext();

    // reset during a locked p1 burst
    setP1(1, 0, 1, 32'h20, 0);
    toNeg();
    chk("rm_gnt1", p1_gnt, 1);
    toNext();
    rst = 1'b1;
    setP1(1, 1, 1, 32'h24, 32'h1234_5678);
    toNeg();
    chk("rm_nowe", mem_we, 0);
    toNext();
    rst = 1'b0;
    setP0(1, 0, 0, 32'h0, 0);
    setP1(1, 0, 0, 32'h4, 0);
    toNeg();
    chk("rm_norv", p1_rvalid, 0);
    chk("rm_mem", mem[9], 32'hA000_0009);
    chk("rm_tie", {p1_gnt, p0_gnt}, 2'b01);
    toNext();
    toNeg();
    chk("rm_next", {p1_gnt, p0_gnt}, 2'b10);
    toNext();
    setP0(0, 0, 0, 0, 0);
    setP1(0, 0, 0, 0, 0);
    toNext();

    // same-cycle p0 write and p1 read of one address
    setP0(1, 1, 0, 32'h8, 32'h5);
    setP1(1, 0, 0, 32'h8, 0);
    toNeg();
    chk("rw_gnt", {p1_gnt, p0_gnt}, 2'b01);
    chk("rw_wd", mem_wdata, 32'h5);
    toNext();
    setP0(0, 0, 0, 0, 0);
    toNeg();
    chk("rw_gnt1", {p1_gnt, p0_gnt}, 2'b10);
    toNext();
    setP1(0, 0, 0, 0, 0);
    toNeg();
    chk("rw_rv1", p1_rvalid, 1);
    chk("rw_rd1", p1_rdata, 32'h5);
    toNext();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
